// File: rtl/ping_pong_checker.sv
// ping_pong_checker: in-fabric golden model of the ping-pong counter.
// The model tracks the counter cycle by cycle from the same control nets and
// flags any difference against the counter's out/direction outputs. Its
// reports are an error pulse, a saturating error count, a sticky fail flag and
// the cycle index of the first mismatch.
module ping_pong_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic             dut_direction,
    input  logic [WIDTH-1:0] dut_out,
    output logic             exp_direction,
    output logic [WIDTH-1:0] exp_out,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic             fail,
    output logic [CYC_W-1:0] first_err_cycle
);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_CHECK = 2'd1,
        ST_FAIL  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    state_t           state_r;
    logic [CYC_W-1:0] cyc_r;
    logic [WIDTH-1:0] exp_out_r;
    logic             exp_dir_r;
    logic             err_r;
    logic [CNT_W-1:0] err_count_r;
    logic             fail_r;
    logic [CYC_W-1:0] first_err_r;

    logic             legal_s;
    logic             nxt_dir_s;
    logic [WIDTH-1:0] nxt_out_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CYC_W-1:0] cyc_inc_s;

    // Next golden-model value; the model never wraps because it only moves when bounds are sane.
    always_comb begin
        nxt_dir_s = exp_dir_r;
        nxt_out_s = exp_out_r;
        legal_s   = (max > min) && (exp_out_r >= min) && (exp_out_r <= max);
        if (!enable || !legal_s) begin
            nxt_dir_s = exp_dir_r;
            nxt_out_s = exp_out_r;
        end else if (flip) begin
            nxt_dir_s = ~exp_dir_r;
            if (!exp_dir_r) begin
                // new direction is up
                if (exp_out_r == max) begin
                    nxt_out_s = max - ONE_W;
                end else begin
                    nxt_out_s = exp_out_r + ONE_W;
                end
            end else begin
                // new direction is down
                if (exp_out_r == min) begin
                    nxt_out_s = min + ONE_W;
                end else begin
                    nxt_out_s = exp_out_r - ONE_W;
                end
            end
        end else if (exp_dir_r && (exp_out_r == max)) begin
            nxt_dir_s = 1'b0;
            nxt_out_s = max - ONE_W;
        end else if (!exp_dir_r && (exp_out_r == min)) begin
            nxt_dir_s = 1'b1;
            nxt_out_s = min + ONE_W;
        end else if (exp_dir_r) begin
            nxt_out_s = exp_out_r + ONE_W;
        end else begin
            nxt_out_s = exp_out_r - ONE_W;
        end
    end

    // Mismatch detect and saturating increments for the counters.
    always_comb begin
        mismatch_s = (dut_out != exp_out_r) || (dut_direction != exp_dir_r);
        if (err_count_r == CNT_MAX) begin
            cnt_inc_s = err_count_r;
        end else begin
            cnt_inc_s = err_count_r + CNT_ONE;
        end
        if (cyc_r == CYC_MAX) begin
            cyc_inc_s = cyc_r;
        end else begin
            cyc_inc_s = cyc_r + CYC_ONE;
        end
    end

    // Model state, cycle counter and ARM/CHECK/FAIL reporting FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ARM;
            cyc_r       <= {CYC_W{1'b0}};
            exp_out_r   <= min;
            exp_dir_r   <= 1'b1;
            err_r       <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
            fail_r      <= 1'b0;
            first_err_r <= {CYC_W{1'b0}};
        end else begin
            exp_out_r <= nxt_out_s;
            exp_dir_r <= nxt_dir_s;
            cyc_r     <= cyc_inc_s;
            case (state_r)
                ST_ARM: begin
                    // DUT and model load together here, so nothing to compare yet
                    err_r   <= 1'b0;
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        err_r       <= 1'b1;
                        err_count_r <= cnt_inc_s;
                        fail_r      <= 1'b1;
                        first_err_r <= cyc_r;
                        state_r     <= ST_FAIL;
                    end else begin
                        err_r <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    if (mismatch_s) begin
                        err_r       <= 1'b1;
                        err_count_r <= cnt_inc_s;
                    end else begin
                        err_r <= 1'b0;
                    end
                end
                default: begin
                    err_r   <= 1'b0;
                    state_r <= ST_ARM;
                end
            endcase
        end
    end

    assign exp_out         = exp_out_r;
    assign exp_direction   = exp_dir_r;
    assign err             = err_r;
    assign err_count       = err_count_r;
    assign fail            = fail_r;
    assign first_err_cycle = first_err_r;

endmodule

// File: tb/tb_ping_pong_checker.sv
// Testbench for ping_pong_checker: a reference counter feeds dut_out, and a
// behavioural model of the checker predicts every output.
module tb_ping_pong_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flip;
    logic [3:0]  max;
    logic [3:0]  min;
    logic        dut_direction;
    logic [3:0]  dut_out;
    logic        exp_direction;
    logic [3:0]  exp_out;
    logic        err;
    logic [7:0]  err_count;
    logic        fail;
    logic [15:0] first_err_cycle;

    int checks = 0;
    int errors = 0;

    // behavioural model of the checker
    int m_out, m_cnt, m_cyc, m_first, since;
    bit m_dir, m_err, m_fail;
    // reference counter that plays the role of the checked design
    int c_out;
    bit c_dir;

    ping_pong_checker #(.WIDTH(4), .CNT_W(8), .CYC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip),
        .max(max), .min(min), .dut_direction(dut_direction), .dut_out(dut_out),
        .exp_direction(exp_direction), .exp_out(exp_out), .err(err),
        .err_count(err_count), .fail(fail), .first_err_cycle(first_err_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One counter step written with a signed step s = +1/-1.
    function automatic void next_val(input int o, input bit d, input bit en, input bit fl,
                                     input int mx, input int mn, output int no, output bit nd);
        int s;
        no = o;
        nd = d;
        if (en && mx > mn && o >= mn && o <= mx) begin
            s = d ? 1 : -1;
            if (fl) begin
                s  = -s;
                no = (o + s > mx || o + s < mn) ? o - s : o + s;
            end else begin
                if (o + s > mx || o + s < mn) s = -s;
                no = o + s;
            end
            nd = (s > 0);
        end
    endfunction

    function automatic logic [30:0] model_vec();
        return {4'(m_out), m_dir, m_err, 8'(m_cnt), m_fail, 16'(m_first)};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {exp_out, exp_direction, err, err_count, fail, first_err_cycle};
    endfunction

    function automatic int tri_wave(input int j);
        int k;
        k = j % 30;
        return (k <= 15) ? k : 30 - k;
    endfunction

    // Advance one clock: predict, let the edge happen, then commit and re-drive dut_out.
    task automatic tick();
        int  no, co;
        bit  nd, cd, mism, r;
        r = rst_n;
        mism = 1'b0;
        if (!r) begin
            no = int'(min); nd = 1'b1; co = int'(min); cd = 1'b1;
        end else begin
            mism = (since >= 1) && ((int'(dut_out) != m_out) || (dut_direction != m_dir));
            next_val(m_out, m_dir, enable, flip, int'(max), int'(min), no, nd);
            next_val(c_out, c_dir, enable, flip, int'(max), int'(min), co, cd);
        end
        @(posedge clk);
        #1;
        if (!r) begin
            m_cnt = 0; m_cyc = 0; m_first = 0; since = 0;
            m_err = 1'b0; m_fail = 1'b0;
        end else begin
            m_err = mism;
            if (mism && m_cnt < 255) m_cnt = m_cnt + 1;
            if (mism && !m_fail) begin
                m_fail  = 1'b1;
                m_first = m_cyc;
            end
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            since = since + 1;
        end
        m_out = no; m_dir = nd; c_out = co; c_dir = cd;
        dut_out       = 4'(c_out);
        dut_direction = c_dir;
    endtask

    task automatic do_reset(input logic [3:0] mn, input logic [3:0] mx);
        rst_n = 1'b0; min = mn; max = mx; enable = 1'b1; flip = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; min = 4'd3; max = 4'd9; enable = 1'($urandom); flip = 1'($urandom);
        dut_out = 4'($urandom); dut_direction = 1'($urandom);
        tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reset_vec got=%h exp=%h", dut_vec(), model_vec());
        end
        checks++;
        if ({exp_out, exp_direction, err, err_count, fail, first_err_cycle} !== {4'd3, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL reset_values got=%h", dut_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_count_run();
        do_reset(4'd0, 4'd15);
        for (int j = 1; j <= 40; j++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL run_vec[%0d] got=%h exp=%h", j, dut_vec(), model_vec());
            end
            checks++;
            if (exp_out !== 4'(tri_wave(j)) || err !== 1'b0 || fail !== 1'b0) begin
                errors++; $display("FAIL run_wave[%0d] got out=%0d err=%b fail=%b exp out=%0d", j, exp_out, err, fail, tri_wave(j));
            end
        end
    endtask

    task automatic test_inject();
        int  inj_cyc;
        bit  injected, was_inj;
        injected = 1'b0;
        inj_cyc  = -1;
        do_reset(4'd0, 4'd15);
        for (int j = 1; j <= 20; j++) begin
            was_inj = 1'b0;
            if (!injected && since >= 1 && m_out == 4) begin
                dut_out = 4'd5; inj_cyc = m_cyc; injected = 1'b1; was_inj = 1'b1;
            end
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL inject_vec[%0d] got=%h exp=%h", j, dut_vec(), model_vec());
            end
            checks++;
            if (err !== was_inj) begin
                errors++; $display("FAIL inject_err[%0d] got=%b exp=%b", j, err, was_inj);
            end
        end
        checks++;
        if (err_count !== 8'd1 || fail !== 1'b1 || first_err_cycle !== 16'(inj_cyc) || inj_cyc != 4) begin
            errors++; $display("FAIL inject_final got cnt=%0d fail=%b first=%0d exp cnt=1 fail=1 first=4 (inj at %0d)", err_count, fail, first_err_cycle, inj_cyc);
        end
    endtask

    task automatic test_flip();
        int n;
        do_reset(4'd0, 4'd15);
        n = 0;
        while (!(m_out == 6 && m_dir) && n < 40) begin tick(); n++; end
        flip = 1'b1;
        tick();
        flip = 1'b0;
        checks++;
        if (exp_out !== 4'd5 || exp_direction !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL flip_mid got out=%0d dir=%b err=%b exp out=5 dir=0", exp_out, exp_direction, err);
        end
        n = 0;
        while (!(m_out == 15 && m_dir) && n < 60) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL flip_vec[%0d] got=%h exp=%h", n, dut_vec(), model_vec());
            end
        end
        flip = 1'b1;
        tick();
        flip = 1'b0;
        checks++;
        if (exp_out !== 4'd14 || exp_direction !== 1'b0 || fail !== 1'b0) begin
            errors++; $display("FAIL flip_top got out=%0d dir=%b fail=%b exp out=14 dir=0", exp_out, exp_direction, fail);
        end
    endtask

    task automatic test_illegal();
        int n;
        logic hold_dir;
        do_reset(4'd0, 4'd15);
        n = 0;
        while (m_out != 2 && n < 40) begin tick(); n++; end
        hold_dir = m_dir;
        max = 4'd3; min = 4'd7;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (exp_out !== 4'd2 || exp_direction !== hold_dir || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL illegal_swap[%0d] got out=%0d dir=%b exp out=2 dir=%b", j, exp_out, exp_direction, hold_dir);
            end
        end
        max = 4'd15; min = 4'd3;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (exp_out !== 4'd2 || exp_direction !== hold_dir || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL illegal_range[%0d] got out=%0d dir=%b exp out=2 dir=%b", j, exp_out, exp_direction, hold_dir);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset(4'd0, 4'd15);
        for (int j = 0; j < 300; j++) begin
            dut_out = 4'd0;
            tick();
            if (j % 25 == 0) begin
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL sat_vec[%0d] got=%h exp=%h", j, dut_vec(), model_vec());
                end
            end
        end
        checks++;
        if (err_count !== 8'd255 || fail !== 1'b1 || first_err_cycle !== 16'd1) begin
            errors++; $display("FAIL sat_final got cnt=%0d fail=%b first=%0d exp cnt=255 fail=1 first=1", err_count, fail, first_err_cycle);
        end
    endtask

    task automatic test_reset_in_fail();
        rst_n = 1'b0; min = 4'd5; max = 4'd12;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({exp_out, exp_direction, err, err_count, fail, first_err_cycle} !== {4'd5, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL rst_fail_values got=%h", dut_vec());
        end
        // garbage during the ARM cycle must not be compared
        dut_out = 4'd0; dut_direction = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec() || err !== 1'b0 || fail !== 1'b0) begin
                errors++; $display("FAIL rst_fail_run[%0d] got=%h exp=%h", j, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 600; j++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            enable = ($urandom_range(0, 9) < 8);
            flip   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
                max = 4'($urandom); min = 4'($urandom);
            end
            if ($urandom_range(0, 19) == 0) dut_out = 4'($urandom);
            if ($urandom_range(0, 39) == 0) dut_direction = ~dut_direction;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random_vec[%0d] got=%h exp=%h", j, dut_vec(), model_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; flip = 1'b0; max = 4'd15; min = 4'd0;
        dut_out = 4'd0; dut_direction = 1'b1;
        m_out = 0; m_dir = 1'b1; m_cnt = 0; m_cyc = 0; m_first = 0; since = 0;
        m_err = 1'b0; m_fail = 1'b0; c_out = 0; c_dir = 1'b1;
        @(negedge clk);
        test_reset();
        test_count_run();
        test_inject();
        test_flip();
        test_illegal();
        test_saturate();
        test_reset_in_fail();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
